// File: rtl/spike_window_counter.sv
// Spike rate decoder: counts spikes over a programmable window, one-entry valid/ready result.
// Optional SPIKE_FIRST_LAT_EN adds out_first_lat (counter index of the window's first spike).
module spike_window_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
`ifdef SPIKE_FIRST_LAT_EN
    output logic [WIN_W-1:0] out_first_lat,
`endif
    output logic [7:0]       drop_count
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [WIN_W-1:0] r_win_reg;
    logic [WIN_W-1:0] r_win_ctr;
    logic [CNT_W-1:0] r_acc;
    logic             r_sat;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_out_sat;
    logic [7:0]       r_drop;

    logic [WIN_W-1:0] w_start_len;
    logic             w_last;
    logic             w_acc_full;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_sat_next;
    logic             w_complete;
    logic             w_accept;

    assign w_start_len = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_last      = (r_win_ctr == r_win_reg - WIN_W'(1));
    assign w_acc_full  = (r_acc == CNT_MAX);
    assign w_acc_next  = w_acc_full ? r_acc : r_acc + CNT_W'(spike_in);
    assign w_sat_next  = r_sat | (w_acc_full & spike_in);
    assign w_complete  = (r_state == S_COUNT) && w_last;
    // A completed window may overwrite the result only if it is empty or leaving this cycle.
    assign w_accept    = !r_valid || out_ready;

`ifdef SPIKE_FIRST_LAT_EN
    // All-ones marks "no spike yet"; a window index never reaches it (max index is 2^WIN_W-2).
    logic [WIN_W-1:0] r_first;
    logic [WIN_W-1:0] r_out_first;
    logic [WIN_W-1:0] w_first_next;

    assign w_first_next  = (r_first == '1 && spike_in) ? r_win_ctr : r_first;
    assign out_first_lat = r_out_first;
`endif

    // NOTE: every state register uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_win_reg <= '0;
            r_win_ctr <= '0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_out_sat <= 1'b0;
            r_drop    <= '0;
`ifdef SPIKE_FIRST_LAT_EN
            r_first     <= '1;
            r_out_first <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_win_reg <= w_start_len;
                        r_win_ctr <= '0;
                        r_acc     <= '0;
                        r_sat     <= 1'b0;
`ifdef SPIKE_FIRST_LAT_EN
                        r_first   <= '1;
`endif
                        r_state   <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_last) begin
                        if (enable) begin
                            r_win_reg <= w_start_len;
                            r_win_ctr <= '0;
                            r_acc     <= '0;
                            r_sat     <= 1'b0;
`ifdef SPIKE_FIRST_LAT_EN
                            r_first   <= '1;
`endif
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_sat     <= w_sat_next;
                        r_win_ctr <= r_win_ctr + WIN_W'(1);
`ifdef SPIKE_FIRST_LAT_EN
                        r_first   <= w_first_next;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_complete) begin
                if (w_accept) begin
                    r_valid   <= 1'b1;
                    r_count   <= w_acc_next;
                    r_out_sat <= w_sat_next;
`ifdef SPIKE_FIRST_LAT_EN
                    r_out_first <= w_first_next;
`endif
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_count  = r_count;
    assign out_sat    = r_out_sat;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_spike_window_counter.sv
// Self-checking bench for spike_window_counter: vector table, corner sequences, random vs model.
module tb_spike_window_counter;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;
    localparam int NOSPK = (1 << WIN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             spike_in = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic [7:0]       drop_count;
`ifdef SPIKE_FIRST_LAT_EN
    logic [WIN_W-1:0] out_first_lat;
`endif

    spike_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_sat    (out_sat),
`ifdef SPIKE_FIRST_LAT_EN
        .out_first_lat(out_first_lat),
`endif
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: integer spike tally per window, result clipped at the end.
    bit m_in_win;
    int m_len, m_n, m_cnt, m_first;
    bit m_valid, m_sat;
    int m_count, m_drop, m_lat;

    function automatic void m_start(input int wl);
        m_in_win = 1'b1;
        m_len    = (wl == 0) ? 1 : wl;
        m_n      = 0;
        m_cnt    = 0;
        m_first  = -1;
    endfunction

    function automatic void m_update(input bit r, input bit en, input bit sp, input int wl,
                                     input bit rdy);
        bit done;
        int res_cnt, res_lat;
        bit res_sat;
        if (r) begin
            m_in_win = 0; m_valid = 0; m_sat = 0; m_count = 0; m_drop = 0; m_lat = 0;
            return;
        end
        done = 0; res_cnt = 0; res_sat = 0; res_lat = 0;
        if (m_in_win) begin
            if (sp) begin
                if (m_first < 0) m_first = m_n;
                m_cnt++;
            end
            m_n++;
            if (m_n == m_len) begin
                done    = 1;
                res_cnt = (m_cnt > MAX) ? MAX : m_cnt;
                res_sat = (m_cnt > MAX);
                res_lat = (m_first < 0) ? NOSPK : m_first;
                if (en) m_start(wl);
                else m_in_win = 0;
            end else if (!en) begin
                m_in_win = 0;
            end
        end else if (en) begin
            m_start(wl);
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_count = res_cnt; m_sat = res_sat; m_lat = res_lat;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endfunction

    task automatic step(input bit r, input bit en, input bit sp, input int wl, input bit rdy);
        rst       = r;
        enable    = en;
        spike_in  = sp;
        win_len   = WIN_W'(wl);
        out_ready = rdy;
        @(posedge clk);
        #1;
        m_update(r, en, sp, wl, rdy);
        check("model_valid", int'(out_valid), int'(m_valid));
        check("model_drop", int'(drop_count), m_drop);
        if (m_valid) begin
            check("model_count", int'(out_count), m_count);
            check("model_sat", int'(out_sat), int'(m_sat));
`ifdef SPIKE_FIRST_LAT_EN
            check("model_first_lat", int'(out_first_lat), m_lat);
`endif
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    typedef struct {
        bit en; bit sp; int wl; bit rdy;
        bit ev; int ec; bit es; int ed;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 1, 4, 1, 0, 0, 0, 0};  // IDLE -> COUNT, this spike is ignored
        tbl[1]  = '{1, 1, 4, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 4, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 4, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 4, 1, 1, 3, 0, 0};
        tbl[5]  = '{1, 0, 4, 1, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 4, 1, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 4, 1, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 4, 1, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 4, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 4, 1, 0, 0, 0, 0};

        do_reset();
        check("reset_valid", int'(out_valid), 0);
        check("reset_count", int'(out_count), 0);
        check("reset_drop", int'(drop_count), 0);

        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].en, tbl[i].sp, tbl[i].wl, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
            check($sformatf("tbl%0d_drop", i), int'(drop_count), tbl[i].ed);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_count", i), int'(out_count), tbl[i].ec);
                check($sformatf("tbl%0d_sat", i), int'(out_sat), int'(tbl[i].es));
            end
        end

        // Saturation: 20 spikes into a 4-bit count.
        do_reset();
        step(0, 1, 0, 20, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 20, 1);
        check("sat_valid", int'(out_valid), 1);
        check("sat_count", int'(out_count), MAX);
        check("sat_flag", int'(out_sat), 1);

        // Backpressure: three 2-cycle windows with out_ready low.
        do_reset();
        step(0, 1, 0, 2, 0);
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 2, 0);
        check("bp_w1_valid", int'(out_valid), 1);
        check("bp_w1_count", int'(out_count), 2);
        step(0, 1, 0, 2, 0);
        step(0, 1, 0, 2, 0);
        check("bp_w2_hold", int'(out_count), 2);
        check("bp_w2_drop", int'(drop_count), 1);
        step(0, 1, 1, 2, 0);
        step(0, 1, 0, 2, 0);
        check("bp_w3_hold", int'(out_count), 2);
        check("bp_w3_drop", int'(drop_count), 2);
        step(0, 0, 0, 2, 1);
        check("bp_xfer_valid", int'(out_valid), 0);
        check("bp_xfer_drop", int'(drop_count), 2);

        // win_len=0 acts as 1-cycle windows.
        do_reset();
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            bit sp;
            sp = (i % 3) != 1;
            step(0, 1, sp, 0, 1);
            check($sformatf("w0_valid%0d", i), int'(out_valid), 1);
            check($sformatf("w0_count%0d", i), int'(out_count), int'(sp));
        end

        // Abort after 5 cycles, then a full 8-cycle window.
        do_reset();
        step(0, 1, 0, 8, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 8, 1);
        step(0, 0, 1, 8, 1);
        check("abort_valid", int'(out_valid), 0);
        step(0, 0, 1, 8, 1);
        check("abort_idle_valid", int'(out_valid), 0);
        step(0, 1, 1, 8, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 8, 1);
        check("reen_early_valid", int'(out_valid), 0);
        step(0, 1, 1, 8, 1);
        check("reen_valid", int'(out_valid), 1);
        check("reen_count", int'(out_count), 8);

        // Reset mid-window with a pending result and a nonzero drop count.
        do_reset();
        step(0, 1, 0, 2, 0);
        step(0, 1, 1, 2, 0);
        step(0, 1, 0, 2, 0);
        step(0, 1, 0, 2, 0);
        step(0, 1, 0, 2, 0);
        check("prerst_drop", int'(drop_count), 1);
        step(0, 1, 1, 2, 0);
        do_reset();
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_count", int'(out_count), 0);
        check("midrst_sat", int'(out_sat), 0);
        check("midrst_drop", int'(drop_count), 0);

`ifdef SPIKE_FIRST_LAT_EN
        do_reset();
        step(0, 1, 0, 8, 1);
        for (int i = 0; i < 8; i++) step(0, 1, (i == 3 || i == 4), 8, 1);
        check("lat_valid", int'(out_valid), 1);
        check("lat_count", int'(out_count), 2);
        check("lat_first", int'(out_first_lat), 3);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8, 1);
        check("lat_none", int'(out_first_lat), NOSPK);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wl;
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24))
                                             : int'($urandom_range(0, 5));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 1) == 1, wl, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_window_counter.md
Name: spike_window_counter

Overview:
Rate decoder that sits directly downstream of the LIF neuron. It counts the neuron's spike output over a programmable window of clock cycles. At the end of each window it presents the spike count on a single-entry valid/ready output register. The readout or learning logic uses this to measure firing rate without sampling the spike wire every cycle.

Parameters:
CNT_W, 8, width of the spike count; the count saturates at 2^CNT_W-1.
WIN_W, 8, width of the window-length input and the internal window counter.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  1 = run back-to-back windows; 0 = abort any window and idle.
spike_in  in  1  spike from the neuron, sampled every cycle.
win_len  in  WIN_W  window length in cycles; latched at each window start; 0 is treated as 1.
out_valid  out  1  result register holds an unconsumed result.
out_ready  in  1  consumer accepts the result.
out_count  out  CNT_W  spikes counted in the completed window (saturated).
out_sat  out  1  the count saturated during that window.
drop_count  out  8  number of window results lost to backpressure; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; out_valid, out_count, out_sat, drop_count, window counter and spike accumulator all 0. Reset mid-window or with a pending result discards everything.
- FSM has two states, IDLE and COUNT.
- IDLE:
  - If enable=1: latch win_reg = (win_len==0 ? 1 : win_len), clear the accumulator and window counter, go to COUNT.
  - A spike_in in this cycle is not counted.
- COUNT: each cycle, acc_next = sat(acc + spike_in) and win_ctr increments.
  - Saturation: if acc is already 2^CNT_W-1 and spike_in=1, acc holds and sat_flag is set.
- Last cycle of a window is the cycle where win_ctr == win_reg-1. The spike in that cycle is included. The window completes with result = acc_next and sat_flag_next.
- After completion:
  - If enable=1: relatch win_len, clear acc, win_ctr and sat_flag, stay in COUNT. Windows run back-to-back with no dead cycle.
  - If enable=0: go to IDLE.
- enable=0 in COUNT before the last cycle: abort. The partial result is discarded, nothing is pushed, and the FSM goes to IDLE next cycle.
- Window duration is exactly win_reg cycles of spike sampling. Latency from the last sampled spike to out_valid=1 is 1 cycle.
- Output push at window completion:
  - If out_valid==0, or out_valid&&out_ready in the same cycle: load out_count/out_sat and set out_valid=1.
  - Otherwise: the result is dropped, the old result is kept, and drop_count increments (saturating at 255).
- Handshake:
  - A transfer occurs when out_valid&&out_ready; out_valid clears unless a push happens in the same cycle.
  - While out_valid=1 and not transferred, out_count and out_sat stay stable.
  - out_ready is ignored when out_valid=0.
- Changes to win_len mid-window have no effect until the next window start.

Optional Feature:
SPIKE_FIRST_LAT_EN
- Defined: adds output port out_first_lat [WIN_W-1:0], registered alongside out_count.
  - It holds the window-counter value (0-based) of the first spike in the window.
  - It holds all-ones if the window had no spike.
  - It follows the same push, hold and drop rules as out_count.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- win_len=4, enable=1, spike_in=1,0,1,1 in the window, out_ready=1 -> out_valid pulses 1 cycle after the 4th sample with out_count=3, out_sat=0; the next window starts with no gap.
- CNT_W=4, win_len=20, spike_in held at 1 -> out_count=15, out_sat=1.
- win_len=2, out_ready=0 for three windows -> the first result is held stable, drop_count=2, then out_ready=1 transfers the first result.
- win_len=0 -> behaves as 1-cycle windows: a result every cycle with out_count = spike_in of that cycle.
- win_len=8, enable dropped after 5 cycles -> no push, IDLE next cycle. Re-enable -> a new full 8-cycle window.
- Assert rst mid-window with out_valid=1 -> all outputs 0 next cycle, drop_count=0. With SPIKE_FIRST_LAT_EN and first spike at cycle 3 of 8 -> out_first_lat=3.
